sram_access_ctrl: RTL and testbench

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

---
 rtl/sram_access_ctrl_if.sv | 25 ++
 rtl/sram_access_ctrl.sv | 118 +++++++++++
 tb/tb_sram_access_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - request/response bus between a requester and the SRAM access controller
interface sram_access_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [2:0]       req_addr_a;
    logic [2:0]       req_addr_b;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - sequences precharge, wordline, write-driver and sense-amp strobes for one SRAM access
module sram_access_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRE_CYCLES = 1,
    parameter int WL_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_access_ctrl_if.slave    bus,
    output logic                 precharge,
    output logic [7:0]           wl_en,
    output logic                 we,
    output logic [WIDTH-1:0]     bl_wdata,
    output logic                 sae,
    input  logic [WIDTH-1:0]     sram_rdata,
    output logic                 busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ACT   = 3'd2;
    localparam logic [2:0] S_SENSE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_COMPUTE = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);
    localparam logic [3:0] ACT_LOAD = 4'(WL_CYCLES - 1);

    logic [2:0]       state;
    logic [3:0]       pre_cnt;
    logic [3:0]       act_cnt;
    logic [1:0]       op_q;
    logic [7:0]       row_mask;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic             accept;
    logic [7:0]       mask_a;
    logic [7:0]       mask_b;

    assign accept = bus.req_valid && (state == S_IDLE);
    assign mask_a = 8'b1 << bus.req_addr_a;
    assign mask_b = 8'b1 << bus.req_addr_b;

    // The row mask is resolved at acceptance so ACT only needs a gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pre_cnt    <= 4'd0;
            act_cnt    <= 4'd0;
            op_q       <= OP_READ;
            row_mask   <= 8'd0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= bus.req_op;
                        wdata_q    <= bus.req_wdata;
                        row_mask   <= (bus.req_op == OP_COMPUTE) ? (mask_a | mask_b) : mask_a;
                        rsp_data_q <= '0;
                        if (bus.req_op == OP_RSVD) begin
                            rsp_err_q <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            pre_cnt <= PRE_LOAD;
                            state   <= S_PRE;
                        end
                    end
                end
                S_PRE: begin
                    if (pre_cnt == 4'd0) begin
                        act_cnt <= ACT_LOAD;
                        state   <= S_ACT;
                    end else begin
                        pre_cnt <= pre_cnt - 4'd1;
                    end
                end
                S_ACT: begin
                    if (act_cnt == 4'd0) begin
                        state <= (op_q == OP_WRITE) ? S_RESP : S_SENSE;
                    end else begin
                        act_cnt <= act_cnt - 4'd1;
                    end
                end
                S_SENSE: begin
                    rsp_data_q <= sram_rdata;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_err_q  <= 1'b0;
                        rsp_data_q <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so reset drops them without a clock.
    assign precharge     = (state == S_PRE);
    assign wl_en         = (state == S_ACT) ? row_mask : 8'd0;
    assign we            = (state == S_ACT) && (op_q == OP_WRITE);
    assign bl_wdata      = we ? wdata_q : '0;
    assign sae           = (state == S_SENSE);
    assign busy          = (state != S_IDLE);
    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - vector table, random model comparison and corner sequences for sram_access_ctrl
module tb_sram_access_ctrl;
    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       req_valid;
    logic [1:0] req_op;
    logic [2:0] req_addr_a, req_addr_b;
    logic [7:0] req_wdata;
    logic       rsp_ready;
    logic [7:0] sram_rdata;

    int checks;
    int errors;

    sram_access_ctrl_if #(.WIDTH(8)) bus0 ();
    sram_access_ctrl_if #(.WIDTH(8)) bus1 ();

    assign bus0.req_valid  = req_valid & ~sel;
    assign bus1.req_valid  = req_valid & sel;
    assign bus0.req_op     = req_op;
    assign bus1.req_op     = req_op;
    assign bus0.req_addr_a = req_addr_a;
    assign bus1.req_addr_a = req_addr_a;
    assign bus0.req_addr_b = req_addr_b;
    assign bus1.req_addr_b = req_addr_b;
    assign bus0.req_wdata  = req_wdata;
    assign bus1.req_wdata  = req_wdata;
    assign bus0.rsp_ready  = rsp_ready & ~sel;
    assign bus1.rsp_ready  = rsp_ready & sel;

    logic       pre0, pre1, we0, we1, sae0, sae1, busy0, busy1;
    logic [7:0] wl0, wl1, bl0, bl1;

    sram_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .precharge(pre0), .wl_en(wl0), .we(we0), .bl_wdata(bl0),
        .sae(sae0), .sram_rdata(sram_rdata), .busy(busy0)
    );

    sram_access_ctrl #(.WIDTH(8), .PRE_CYCLES(3), .WL_CYCLES(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .precharge(pre1), .wl_en(wl1), .we(we1), .bl_wdata(bl1),
        .sae(sae1), .sram_rdata(sram_rdata), .busy(busy1)
    );

    logic       s_pre, s_we, s_sae, s_busy, s_ready, s_rvalid, s_err;
    logic [7:0] s_wl, s_bl, s_data;

    always_comb begin
        s_pre    = sel ? pre1  : pre0;
        s_we     = sel ? we1   : we0;
        s_sae    = sel ? sae1  : sae0;
        s_busy   = sel ? busy1 : busy0;
        s_wl     = sel ? wl1   : wl0;
        s_bl     = sel ? bl1   : bl0;
        s_ready  = sel ? bus1.req_ready : bus0.req_ready;
        s_rvalid = sel ? bus1.rsp_valid : bus0.rsp_valid;
        s_err    = sel ? bus1.rsp_err   : bus0.rsp_err;
        s_data   = sel ? bus1.rsp_data  : bus0.rsp_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [7:0] wd;
        logic [7:0] rd;
        logic [7:0] exp_wl;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        int         hold;
    } vec_t;

    // Drives one request and measures strobe counts, latency and response.
    task automatic run_txn(input logic s, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [7:0] wd, input logic [7:0] rd, input logic [7:0] exp_wl,
                           input logic [7:0] exp_data, input logic exp_err, input int exp_lat,
                           input int hold, input string tag);
        int p, w, pc, wc, wec, sc, lat;
        logic wl_bad, bl_bad, ovl, ready_bad;
        logic [7:0] data0;
        logic err0;
        p = s ? 3 : 1;
        w = s ? 1 : 2;
        pc = 0; wc = 0; wec = 0; sc = 0; lat = -1;
        wl_bad = 0; bl_bad = 0; ovl = 0; ready_bad = 0;
        @(negedge clk);
        sel = s;
        rsp_ready = 1'b0;
        #1;
        chk({tag, ".req_ready_idle"}, 32'(s_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr_a = a; req_addr_b = b; req_wdata = wd;
        @(negedge clk);
        for (int n = 0; n < 60 && lat < 0; n++) begin
            if (s_rvalid) begin
                lat = n;
            end else begin
                req_valid  = 1'($urandom);
                req_op     = 2'($urandom);
                req_addr_a = 3'($urandom);
                req_addr_b = 3'($urandom);
                req_wdata  = 8'($urandom);
                if (s_pre) pc++;
                if (s_wl != 8'd0) begin
                    wc++;
                    if (s_wl != exp_wl) wl_bad = 1'b1;
                end
                if (s_we) wec++;
                if (s_sae) sc++;
                if ((s_we && s_bl != wd) || (!s_we && s_bl != 8'd0)) bl_bad = 1'b1;
                if (s_pre && (s_wl != 8'd0 || s_we || s_sae)) ovl = 1'b1;
                if (s_sae && s_wl != 8'd0) ovl = 1'b1;
                if (s_ready || !s_busy) ready_bad = 1'b1;
                sram_rdata = s_sae ? rd : 8'($urandom);
                @(negedge clk);
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".precharge_cycles"}, 32'(pc), 32'((op == 2'b11) ? 0 : p));
        chk({tag, ".wl_cycles"}, 32'(wc), 32'((op == 2'b11) ? 0 : w));
        chk({tag, ".we_cycles"}, 32'(wec), 32'((op == 2'b01) ? w : 0));
        chk({tag, ".sae_cycles"}, 32'(sc), 32'((op == 2'b00 || op == 2'b10) ? 1 : 0));
        chk({tag, ".wl_value_bad"}, 32'(wl_bad), 32'd0);
        chk({tag, ".bl_wdata_bad"}, 32'(bl_bad), 32'd0);
        chk({tag, ".strobe_overlap"}, 32'(ovl), 32'd0);
        chk({tag, ".busy_ready_bad"}, 32'(ready_bad), 32'd0);
        chk({tag, ".rsp_data"}, 32'(s_data), 32'(exp_data));
        chk({tag, ".rsp_err"}, 32'(s_err), 32'(exp_err));
        data0 = s_data;
        err0 = s_err;
        req_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            sram_rdata = 8'($urandom);
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(s_rvalid), 32'd1);
            chk({tag, ".hold_data"}, 32'(s_data), 32'(data0));
            chk({tag, ".hold_err"}, 32'(s_err), 32'(err0));
            chk({tag, ".hold_req_ready"}, 32'(s_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".post_rsp_valid"}, 32'(s_rvalid), 32'd0);
        chk({tag, ".post_req_ready"}, 32'(s_ready), 32'd1);
        chk({tag, ".post_rsp_err"}, 32'(s_err), 32'd0);
        chk({tag, ".post_busy"}, 32'(s_busy), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [1:0] op;
        logic [2:0] a, b;
        logic [7:0] wd, rd, ewl, edata;
        logic s;
        int lat;
        checks = 0; errors = 0;
        sel = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr_a = 3'd0; req_addr_b = 3'd0;
        req_wdata = 8'd0; rsp_ready = 1'b0; sram_rdata = 8'd0;
        rst_n = 1'b0;

        vecs[0] = '{2'b00, 3'd5, 3'd0, 8'h00, 8'hA5, 8'h20, 8'hA5, 1'b0, 4, 1};
        vecs[1] = '{2'b01, 3'd0, 3'd6, 8'h3C, 8'h77, 8'h01, 8'h00, 1'b0, 3, 0};
        vecs[2] = '{2'b10, 3'd2, 3'd7, 8'h11, 8'h5A, 8'h84, 8'h5A, 1'b0, 4, 2};
        vecs[3] = '{2'b10, 3'd3, 3'd3, 8'h22, 8'hC3, 8'h08, 8'hC3, 1'b0, 4, 0};
        vecs[4] = '{2'b11, 3'd1, 3'd2, 8'h99, 8'h66, 8'h00, 8'h00, 1'b1, 0, 5};
        vecs[5] = '{2'b00, 3'd7, 3'd1, 8'h00, 8'hFF, 8'h80, 8'hFF, 1'b0, 4, 0};

        #12;
        chk("reset.req_ready", 32'(bus0.req_ready), 32'd1);
        chk("reset.busy", 32'(busy0), 32'd0);
        chk("reset.precharge", 32'(pre0), 32'd0);
        chk("reset.wl_en", 32'(wl0), 32'd0);
        chk("reset.we_sae", 32'({we0, sae0}), 32'd0);
        chk("reset.bl_wdata", 32'(bl0), 32'd0);
        chk("reset.rsp", 32'({bus0.rsp_valid, bus0.rsp_err, bus0.rsp_data}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_txn(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wd, vecs[i].rd, vecs[i].exp_wl,
                    vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].hold,
                    $sformatf("vec%0d", i));
        end

        run_txn(1'b1, 2'b00, 3'd4, 3'd0, 8'h00, 8'h3E, 8'h10, 8'h3E, 1'b0, 5, 0, "sweep_read");
        run_txn(1'b1, 2'b01, 3'd6, 3'd0, 8'hB4, 8'h00, 8'h40, 8'h00, 1'b0, 4, 0, "sweep_write");

        // Reset pulled asynchronously in the middle of a write's ACT phase.
        @(negedge clk);
        sel = 1'b0;
        req_valid = 1'b1; req_op = 2'b01; req_addr_a = 3'd4; req_wdata = 8'h99;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid.act_wl", 32'(wl0), 32'h10);
        chk("rst_mid.act_we", 32'(we0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.wl_en", 32'(wl0), 32'd0);
        chk("rst_mid.we", 32'(we0), 32'd0);
        chk("rst_mid.busy", 32'(busy0), 32'd0);
        chk("rst_mid.bl_wdata", 32'(bl0), 32'd0);
        chk("rst_mid.req_ready", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b0, 2'b00, 3'd1, 3'd0, 8'h00, 8'h5C, 8'h02, 8'h5C, 1'b0, 4, 0, "after_rst");

        // Random traffic scored against the access rules.
        for (int i = 0; i < 40; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            op = 2'($urandom_range(0, 3));
            a  = 3'($urandom);
            b  = 3'($urandom);
            wd = 8'($urandom);
            rd = 8'($urandom);
            ewl = (8'd1 << a) | ((op == 2'b10) ? (8'd1 << b) : 8'd0);
            edata = (op == 2'b00 || op == 2'b10) ? rd : 8'd0;
            if (op == 2'b11) lat = 0;
            else lat = (s ? 4 : 3) + ((op == 2'b01) ? 0 : 1);
            run_txn(s, op, a, b, wd, rd, ewl, edata, (op == 2'b11), lat,
                    $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
